// File: rtl/afe_spi_master_if.sv
// Register-port bundle between the brightness-adjust stage, the SPI master
// and the AFE4403 pins. The master modport is the SPI block's view.
interface afe_spi_master_if;
  logic        wr_en;
  logic [7:0]  tx_data;
  logic        spi_miso;
  logic [1:0]  data_part;
  logic        spi_done;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_ste;
  logic [23:0] rx_data;
  logic        rx_valid;
  logic        busy;

  modport master (
    input  wr_en, tx_data, spi_miso,
    output data_part, spi_done, spi_sclk, spi_mosi, spi_ste, rx_data, rx_valid, busy
  );

  modport slave (
    output wr_en, tx_data, spi_miso,
    input  data_part, spi_done, spi_sclk, spi_mosi, spi_ste, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/afe_spi_master.sv
// AFE4403 SPI master (mode 0). One request = one 4-byte frame: address byte
// then three data bytes, MSB first. MISO of bytes 1..3 lands in rx_data.
// All outputs come straight from flops.
module afe_spi_master #(
  parameter int SCLK_HALF = 2,
  parameter int STE_GAP   = 4
) (
  input logic              div_clk,
  input logic              rst,
  afe_spi_master_if.master bus
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int GW = (STE_GAP > 1) ? $clog2(STE_GAP) : 1;
  localparam logic [HW-1:0] HLAST = HW'(SCLK_HALF - 1);
  localparam logic [GW-1:0] GLAST = GW'(STE_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, DONE, GAP} state_e;

  state_e      state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;   // cycles within one SCLK half-period
  logic [3:0]  half_q, half_d;     // SCLK half-period index; bit 0 is SCLK itself
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [1:0]  part_q, part_d;
  logic        ste_q, ste_d;
  logic        mosi_q, mosi_d;
  logic [6:0]  tx_sr_q, tx_sr_d;   // bits still to send after the one on MOSI
  logic [23:0] rx_sr_q, rx_sr_d;   // 24 deep, so byte 0 falls out on its own
  logic [23:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        done_q, busy_q;

  // FSM state register
  always_ff @(posedge div_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    half_d     = half_q;
    gcnt_d     = gcnt_q;
    part_d     = part_q;
    ste_d      = ste_q;
    mosi_d     = mosi_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: if (bus.wr_en) begin
        state_d = SETUP;
        ste_d   = 1'b0;
        part_d  = 2'd0;
      end
      // tx_data for the new data_part is registered upstream; give it a cycle
      SETUP: state_d = LOAD;
      LOAD: begin
        tx_sr_d = bus.tx_data[6:0];
        mosi_d  = bus.tx_data[7];
        hcnt_d  = '0;
        half_d  = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (hcnt_q == HLAST) begin
          hcnt_d = '0;
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            // SCLK about to rise: sample MISO
            rx_sr_d = {rx_sr_q[22:0], bus.spi_miso};
          end else if (half_q != 4'd15) begin
            // SCLK about to fall: present next bit (not after the last one)
            mosi_d  = tx_sr_q[6];
            tx_sr_d = {tx_sr_q[5:0], 1'b0};
          end
          if (half_q == 4'd15) state_d = DONE;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      DONE: begin
        if (part_q != 2'd3) begin
          part_d  = part_q + 2'd1;
          state_d = SETUP;
        end else begin
          part_d     = 2'd0;
          ste_d      = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          gcnt_d     = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (gcnt_q == GLAST) state_d = IDLE;
        else                 gcnt_d  = gcnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge div_clk) begin
    if (rst) begin
      hcnt_q     <= '0;
      half_q     <= 4'd0;
      gcnt_q     <= '0;
      part_q     <= 2'd0;
      ste_q      <= 1'b1;
      mosi_q     <= 1'b0;
      tx_sr_q    <= 7'd0;
      rx_sr_q    <= 24'd0;
      rx_data_q  <= 24'd0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      half_q     <= half_d;
      gcnt_q     <= gcnt_d;
      part_q     <= part_d;
      ste_q      <= ste_d;
      mosi_q     <= mosi_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= (state_d == DONE);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.data_part = part_q;
  assign bus.spi_done  = done_q;
  assign bus.spi_sclk  = half_q[0];
  assign bus.spi_mosi  = mosi_q;
  assign bus.spi_ste   = ste_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_afe_spi_master.sv
// Bench for afe_spi_master: two instances (defaults, and SCLK_HALF=1/STE_GAP=1)
// share rst/wr_en. A frame-timing model derived from byte/bit arithmetic
// checks every output every cycle; directed phases pin the model with literals.
module tb_afe_spi_master;

  logic div_clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [31:0] cur_word;   // slave's MISO frame word, changed only while idle

  always #5 div_clk = ~div_clk;

  afe_spi_master_if if0();
  afe_spi_master_if if1();

  afe_spi_master #(.SCLK_HALF(2), .STE_GAP(4)) u0 (.div_clk(div_clk), .rst(rst), .bus(if0.master));
  afe_spi_master #(.SCLK_HALF(1), .STE_GAP(1)) u1 (.div_clk(div_clk), .rst(rst), .bus(if1.master));

  logic [7:0] tx_tab [4] = '{8'h22, 8'h00, 8'h14, 8'h14};
  int HH [2] = '{2, 1};
  int GG [2] = '{4, 1};

  logic        ste [2], sclk [2], mosi [2], done [2], rxv [2], busy [2], miso [2];
  logic [1:0]  part [2];
  logic [23:0] rxd [2];
  logic [7:0]  txd [2];
  logic [31:0] mo_word [2];

  assign ste[0] = if0.spi_ste;   assign ste[1] = if1.spi_ste;
  assign sclk[0] = if0.spi_sclk; assign sclk[1] = if1.spi_sclk;
  assign mosi[0] = if0.spi_mosi; assign mosi[1] = if1.spi_mosi;
  assign done[0] = if0.spi_done; assign done[1] = if1.spi_done;
  assign rxv[0] = if0.rx_valid;  assign rxv[1] = if1.rx_valid;
  assign busy[0] = if0.busy;     assign busy[1] = if1.busy;
  assign part[0] = if0.data_part; assign part[1] = if1.data_part;
  assign rxd[0] = if0.rx_data;   assign rxd[1] = if1.rx_data;
  assign txd[0] = tx_tab[part[0]]; assign txd[1] = tx_tab[part[1]];
  assign if0.wr_en = wr_en;      assign if1.wr_en = wr_en;
  assign if0.tx_data = txd[0];   assign if1.tx_data = txd[1];
  assign if0.spi_miso = miso[0]; assign if1.spi_miso = miso[1];

  // Mode-0 slave: bit n of the frame is presented after the n-th SCLK fall.
  // Also collect the MOSI stream at SCLK rising edges.
  for (genvar d = 0; d < 2; d++) begin : mon
    logic [4:0]  sidx;
    logic [4:0]  bi;
    logic [31:0] mo_sr;
    always @(negedge sclk[d] or posedge ste[d])
      if (ste[d]) sidx <= 5'd0;
      else        sidx <= sidx + 5'd1;
    assign bi = 5'd31 - sidx;
    assign miso[d] = cur_word[bi];
    always @(posedge sclk[d]) mo_sr <= {mo_sr[30:0], mosi[d]};
    assign mo_word[d] = mo_sr;
  end

  int tests = 0, fails = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic expire(input string nm);
    tests++; fails++;
    $display("FAIL %s: wait bound expired @cyc %0d", nm, cyc);
  endtask

  // Model state and bookkeeping
  logic        act [2];
  int          t [2];
  logic [31:0] frm_word [2];
  logic [23:0] rx_exp [2];
  int done_cyc [2][32], done_part [2][32], n_done [2];
  int rxv_cyc [2], n_rxv [2];
  int runs [2][64], n_runs [2], hi_start [2];
  logic ste_prev [2], busy_prev [2];
  int bz_start [2], bz_len [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; t[d] = 0; rx_exp[d] = 0; n_done[d] = 0; n_rxv[d] = 0; n_runs[d] = 0;
      hi_start[d] = 0; ste_prev[d] = 1; busy_prev[d] = 0; bz_start[d] = 0; bz_len[d] = 0;
      rxv_cyc[d] = 0; frm_word[d] = 0;
    end
    forever begin
      @(posedge div_clk);
      // advance model with inputs as the DUT saw them on this edge
      for (int d = 0; d < 2; d++) begin
        int b;
        b = 16 * HH[d] + 3;
        if (rst) begin act[d] = 0; rx_exp[d] = 24'd0; end
        else if (act[d]) begin
          t[d]++;
          if (t[d] == 4 * b) rx_exp[d] = frm_word[d][23:0];
          if (t[d] == 4 * b + GG[d]) act[d] = 0;
        end else if (wr_en) begin
          act[d] = 1; t[d] = 0; frm_word[d] = cur_word;
        end
      end
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        int b, by, o, e_part;
        logic e_ste, e_sclk, e_done, e_rxv, e_busy;
        b = 16 * HH[d] + 3;
        e_ste = 1; e_sclk = 0; e_done = 0; e_rxv = 0; e_busy = 0; e_part = 0;
        if (act[d]) begin
          e_busy = 1;
          if (t[d] < 4 * b) begin
            by = t[d] / b; o = t[d] % b;
            e_ste = 0; e_part = by; e_done = (o == b - 1);
            if (o >= 2 && o < 2 + 16 * HH[d]) e_sclk = (((o - 2) / HH[d]) % 2) == 1;
            if (e_sclk) chk($sformatf("d%0d_mosi", d), 32'(mosi[d]),
                            32'(tx_tab[by][7 - (o - 2) / (2 * HH[d])]));
          end else e_rxv = (t[d] == 4 * b);
        end
        chk($sformatf("d%0d_ste", d), 32'(ste[d]), 32'(e_ste));
        chk($sformatf("d%0d_sclk", d), 32'(sclk[d]), 32'(e_sclk));
        chk($sformatf("d%0d_done", d), 32'(done[d]), 32'(e_done));
        chk($sformatf("d%0d_rxvalid", d), 32'(rxv[d]), 32'(e_rxv));
        chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(e_busy));
        chk($sformatf("d%0d_part", d), 32'(part[d]), 32'(e_part));
        chk($sformatf("d%0d_rxdata", d), 32'(rxd[d]), 32'(rx_exp[d]));
        // bookkeeping for the directed phases
        if (done[d] === 1'b1 && n_done[d] < 32) begin
          done_cyc[d][n_done[d]] = cyc; done_part[d][n_done[d]] = int'(part[d]); n_done[d]++;
        end
        if (rxv[d] === 1'b1) begin rxv_cyc[d] = cyc; n_rxv[d]++; end
        if (ste[d] === 1'b1 && ste_prev[d] === 1'b0) hi_start[d] = cyc;
        if (ste[d] === 1'b0 && ste_prev[d] === 1'b1 && n_runs[d] < 64) begin
          runs[d][n_runs[d]] = cyc - hi_start[d]; n_runs[d]++;
        end
        ste_prev[d] = ste[d];
        if (busy[d] === 1'b1 && busy_prev[d] === 1'b0) bz_start[d] = cyc;
        if (busy[d] === 1'b0 && busy_prev[d] === 1'b1) bz_len[d] = cyc - bz_start[d];
        busy_prev[d] = busy[d];
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge div_clk);
    while ((busy[0] || busy[1]) && n < 2000) begin @(negedge div_clk); n++; end
    if (n >= 2000) expire(nm);
  endtask

  initial begin
    int base, nd, nr, n, cnt;
    rst = 1'b1; wr_en = 1'b1; cur_word = 32'h7EA55AC3;

    // T1: reset held 3 cycles with wr_en high
    for (int i = 0; i < 3; i++) begin
      @(posedge div_clk); @(negedge div_clk);
      chk("t1_ste", 32'(ste[0]), 32'd1);
      chk("t1_busy", 32'(busy[0]), 32'd0);
      chk("t1_sclk", 32'(sclk[0]), 32'd0);
    end
    rst = 1'b0;
    @(negedge div_clk);
    chk("t1_start_ste", 32'(ste[0]), 32'd0);
    chk("t1_start_ste_b", 32'(ste[1]), 32'd0);
    wr_en = 1'b0;

    // T2/T3/T6: single write/read frame on both instances
    wait_idle("t2_idle");
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("t2_d%0d_ndone", d), 32'(n_done[d]), 32'd4);
      for (int i = 0; i < 3; i++)
        chk($sformatf("t2_d%0d_byte_time", d), 32'(done_cyc[d][i+1] - done_cyc[d][i]),
            (d == 0) ? 32'd35 : 32'd19);
      for (int i = 0; i < 4; i++)
        chk($sformatf("t2_d%0d_part_seq", d), 32'(done_part[d][i]), 32'(i));
      chk($sformatf("t2_d%0d_mosi_stream", d), mo_word[d], 32'h22001414);
      chk($sformatf("t3_d%0d_rx", d), 32'(rxd[d]), 32'h00A55AC3);
      chk($sformatf("t3_d%0d_rxv_lat", d), 32'(rxv_cyc[d] - done_cyc[d][3]), 32'd1);
      chk($sformatf("t3_d%0d_nrxv", d), 32'(n_rxv[d]), 32'd1);
      chk($sformatf("t6_d%0d_frame_gap", d), 32'(bz_len[d]), (d == 0) ? 32'd144 : 32'd77);
    end

    // T4: back-to-back frames with wr_en held high
    cur_word = 32'h00123456;
    base = n_runs[0]; nd = n_runs[1];
    nr = n_rxv[0];
    @(negedge div_clk); wr_en = 1'b1;
    n = 0;
    while (n_rxv[0] < nr + 3 && n < 800) begin @(negedge div_clk); n++; end
    if (n >= 800) expire("t4_frames");
    wr_en = 1'b0;
    wait_idle("t4_idle");
    cnt = 0;
    for (int i = base + 1; i < n_runs[0]; i++) begin
      chk("t4_d0_ste_gap", 32'(runs[0][i]), 32'd5); cnt++;
    end
    chk("t4_d0_gap_count", 32'(cnt >= 2), 32'd1);
    cnt = 0;
    for (int i = nd + 1; i < n_runs[1]; i++) begin
      chk("t4_d1_ste_gap", 32'(runs[1][i]), 32'd2); cnt++;
    end
    chk("t4_d1_gap_count", 32'(cnt >= 2), 32'd1);
    chk("t4_d0_rx", 32'(rxd[0]), 32'h00123456);

    // T5: reset during byte-2 SHIFT, then the frame restarts from address byte
    cur_word = 32'h11223344;
    @(negedge div_clk); wr_en = 1'b1;
    n = 0;
    while (!(part[0] == 2'd2 && sclk[0] == 1'b1) && n < 400) begin @(negedge div_clk); n++; end
    if (n >= 400) expire("t5_reach_byte2");
    nd = n_done[0]; nr = n_rxv[0];
    rst = 1'b1;
    @(negedge div_clk);
    chk("t5_ste", 32'(ste[0]), 32'd1);
    chk("t5_sclk", 32'(sclk[0]), 32'd0);
    chk("t5_done", 32'(done[0]), 32'd0);
    chk("t5_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0;
    @(negedge div_clk);
    chk("t5_restart_ste", 32'(ste[0]), 32'd0);
    chk("t5_restart_part", 32'(part[0]), 32'd0);
    chk("t5_no_done", 32'(n_done[0]), 32'(nd));
    chk("t5_no_rxv", 32'(n_rxv[0]), 32'(nr));
    wr_en = 1'b0;
    wait_idle("t5_idle");
    chk("t5_rx", 32'(rxd[0]), 32'h00223344);
    chk("t5_mosi_stream", mo_word[0], 32'h22001414);

    repeat (3) @(negedge div_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
